// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle RV32I control slice.
//   - state_t     : sequencer states (S_TRAP only reachable with ILLEGAL_TRAP_EN)
//   - alu_op_t    : ALU operation class driven from the FSM into alu_decoder
//   - OP_*        : opcode constants for lw, sw and R-type
//   - ALU_*       : alu_control encodings
//   - SRCA_/SRCB_/RES_/ADR_/IMM_ : mux-select encodings
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_TRAP     = 4'd8
  } state_t;

  typedef enum logic {
    ALUOP_ADD   = 1'b0,
    ALUOP_RTYPE = 1'b1
  } alu_op_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SUB     = 3'b001;
  localparam logic [2:0] ALU_AND     = 3'b010;
  localparam logic [2:0] ALU_OR      = 3'b011;
  localparam logic [2:0] ALU_INVALID = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;

  // True for the two opcodes that go through the address-compute state.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational mapping of ALU class + func3/func7 to alu_control.
// Ports:
//   i_alu_op      in  ALU class (add for address/PC math, R-type for EXECR)
//   i_func3       in  instr[14:12]
//   i_func7       in  instr[31:25]; only bit 5 (sub vs add) is significant
//   o_alu_control out ALU operation encoding
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_op_t     i_alu_op,
  input  logic [2:0]  i_func3,
  input  logic [6:0]  i_func7,
  output logic [2:0]  o_alu_control
);

  // Remaining func7 bits are deliberately ignored by this subset.
  logic w_unused_func7;
  assign w_unused_func7 = ^{i_func7[6], i_func7[4:0]};

  always_comb begin
    o_alu_control = ALU_ADD;
    if (i_alu_op == ALUOP_RTYPE) begin
      case (i_func3)
        3'b000:  o_alu_control = i_func7[5] ? ALU_SUB : ALU_ADD;
        3'b111:  o_alu_control = ALU_AND;
        3'b110:  o_alu_control = ALU_OR;
        default: o_alu_control = ALU_INVALID;
      endcase
    end else begin
      o_alu_control = ALU_ADD;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle sequencer for lw, sw and R-type add/sub/and/or
// sharing one memory port with a ready handshake.
// Optional feature macro: ILLEGAL_TRAP_EN (adds TRAP state and illegal_instr).
// Ports:
//   clk, reset            clock (rising) and asynchronous active-high reset
//   op, func3, func7      instruction fields from the instruction register
//   mem_ready             memory completes the current access this cycle
//   mem_req/mem_write     memory request and store qualifier
//   adr_source            memory address select (PC / ALU-out register)
//   ir_write, pc_write    fetch-handshake pulses (Mealy on mem_ready)
//   reg_write             register file write enable
//   alu_src_a/alu_src_b   ALU operand selects
//   result_src            result bus select
//   imm_source            immediate format select
//   illegal_instr         trap flag (ILLEGAL_TRAP_EN only)
//   alu_control           ALU operation
// Outputs are decoded from the registered state so that ir_write/pc_write can
// follow mem_ready within the handshake cycle; all are forced low in reset.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_source,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_source,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal_instr,
`endif
  output logic [2:0] alu_control
);

  state_t     r_state;
  alu_op_t    w_alu_op;
  logic [2:0] w_alu_control;

  assign w_alu_op = (r_state == S_EXECR) ? ALUOP_RTYPE : ALUOP_ADD;

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_func3       (func3),
    .i_func7       (func7),
    .o_alu_control (w_alu_control)
  );

  // State register and transition logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (is_mem_op(op)) begin
            r_state <= S_MEMADR;
          end else if (op == OP_RTYPE) begin
            r_state <= S_EXECR;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            r_state <= S_TRAP;
`else
            // Unknown opcode retires as a NOP.
            r_state <= S_FETCH;
`endif
          end
        end
        S_MEMADR:   r_state <= (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:     r_state <= S_TRAP;
`endif
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode from current state; everything low while reset is held.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_source  = ADR_PC;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    imm_source  = IMM_I;
    alu_control = w_alu_control;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        adr_source = ADR_PC;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Branch-target precompute; result is not consumed by this subset.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_source = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        adr_source = ADR_ALUOUT;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_DATA;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_source = ADR_ALUOUT;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
    if (reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_source  = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      imm_source  = 2'b00;
      alu_control = 3'b000;
    end else begin
      alu_control = alu_control;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Trap flag, held until reset.
  always_comb begin
    if (reset) begin
      illegal_instr = 1'b0;
    end else begin
      illegal_instr = (r_state == S_TRAP);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. Outputs are packed into
// one 17-bit vector and compared at the falling edge against hand-built
// per-state vectors. Inputs change 1 time unit after the rising edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic [6:0] func7 = 7'd0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_source, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_source;
  logic [2:0] alu_control;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  int total = 0;
  int bad = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .func3(func3), .func7(func7),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_source(adr_source), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_source(imm_source),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .alu_control(alu_control)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_write, adr_source, ir_write, pc_write, reg_write,
  //  alu_src_a, alu_src_b, result_src, imm_source, alu_control}
  logic [16:0] obs;
  assign obs = {mem_req, mem_write, adr_source, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, imm_source, alu_control};

  localparam logic [16:0] V_ZERO       = 17'd0;
  localparam logic [16:0] V_FETCH_WAIT = 17'b1_0_0_0_0_0_00_10_10_00_000;
  localparam logic [16:0] V_FETCH_GO   = 17'b1_0_0_1_1_0_00_10_10_00_000;
  localparam logic [16:0] V_DECODE     = 17'b0_0_0_0_0_0_01_01_00_00_000;
  localparam logic [16:0] V_MEMADR_LW  = 17'b0_0_0_0_0_0_10_01_00_00_000;
  localparam logic [16:0] V_MEMADR_SW  = 17'b0_0_0_0_0_0_10_01_00_01_000;
  localparam logic [16:0] V_MEMREAD    = 17'b1_0_1_0_0_0_00_00_00_00_000;
  localparam logic [16:0] V_MEMWB      = 17'b0_0_0_0_0_1_00_00_01_00_000;
  localparam logic [16:0] V_MEMWRITE   = 17'b1_1_1_0_0_0_00_00_00_00_000;
  localparam logic [16:0] V_EXECR_ADD  = 17'b0_0_0_0_0_0_10_00_00_00_000;
  localparam logic [16:0] V_ALUWB      = 17'b0_0_0_0_0_1_00_00_00_00_000;

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (obs !== V_ZERO) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", obs, V_ZERO);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== V_FETCH_WAIT) begin
      bad++; $display("FAIL first_fetch got=%b want=%b", obs, V_FETCH_WAIT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype_add();
    logic [16:0] exp [5];
    logic        rdy [5];
    exp = '{V_FETCH_GO, V_DECODE, V_EXECR_ADD, V_ALUWB, V_FETCH_WAIT};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    op = 7'b0110011; func3 = 3'b000; func7 = 7'b0000000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL add_step%0d got=%b want=%b", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_ops();
    logic [2:0] f3 [4];
    logic [6:0] f7 [4];
    logic [2:0] ac [4];
    f3 = '{3'b000, 3'b111, 3'b110, 3'b100};
    f7 = '{7'b0100000, 7'b0000000, 7'b0000000, 7'b0000000};
    ac = '{3'b001, 3'b010, 3'b011, 3'b111};
    op = 7'b0110011;
    for (int k = 0; k < 4; k++) begin
      func3 = f3[k]; func7 = f7[k];
      mem_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;   // FETCH handshake
      mem_ready = 1'b1;     // ignored outside memory states
      @(posedge clk); #1;   // DECODE
      @(negedge clk);
      total++;
      if (obs !== (V_EXECR_ADD | {14'd0, ac[k]})) begin
        bad++; $display("FAIL rtype_op%0d got=%b want=%b", k, obs, V_EXECR_ADD | {14'd0, ac[k]});
      end
      @(posedge clk); #1;   // ALUWB
      mem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== V_ALUWB) begin
        bad++; $display("FAIL rtype_wb%0d got=%b want=%b", k, obs, V_ALUWB);
      end
      @(posedge clk); #1;   // FETCH, waiting
    end
  endtask

  task automatic test_lw_wait();
    logic [16:0] exp [9];
    logic        rdy [9];
    exp = '{V_FETCH_GO, V_DECODE, V_MEMADR_LW, V_MEMREAD, V_MEMREAD, V_MEMREAD,
            V_MEMREAD, V_MEMWB, V_FETCH_WAIT};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    op = 7'b0000011; func3 = 3'b010; func7 = 7'b0000000;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL lw_step%0d got=%b want=%b", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [16:0] exp [5];
    logic        rdy [5];
    exp = '{V_FETCH_GO, V_DECODE, V_MEMADR_SW, V_MEMWRITE, V_FETCH_WAIT};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = 7'b0100011; func3 = 3'b010; func7 = 7'b0000000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL sw_step%0d got=%b want=%b", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [11];
    logic        rdy [11];
    logic [6:0]  ops [11];
    // Fetch waits twice, sw with one write wait, then lw with zero wait.
    exp = '{V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_GO, V_DECODE, V_MEMADR_SW,
            V_MEMWRITE, V_MEMWRITE, V_FETCH_GO, V_DECODE, V_MEMADR_LW, V_MEMREAD};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    ops = '{7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011,
            7'b0100011, 7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011};
    for (int i = 0; i < 11; i++) begin
      mem_ready = rdy[i];
      op = ops[i];
      @(negedge clk);
      total++;
      if (obs !== exp[i]) begin
        bad++; $display("FAIL b2b_step%0d got=%b want=%b", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== V_MEMWB) begin
      bad++; $display("FAIL b2b_memwb got=%b want=%b", obs, V_MEMWB);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    op = 7'b0000011;
    mem_ready = 1'b1;
    @(posedge clk); #1;   // FETCH -> DECODE
    mem_ready = 1'b0;
    @(posedge clk); #1;   // DECODE -> MEMADR
    @(posedge clk); #1;   // MEMADR -> MEMREAD
    @(posedge clk); #1;   // MEMREAD waiting
    total++;
    if (obs !== V_MEMREAD) begin
      bad++; $display("FAIL rst_pre got=%b want=%b", obs, V_MEMREAD);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs !== V_ZERO) begin
      bad++; $display("FAIL rst_async got=%b want=%b", obs, V_ZERO);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== V_ZERO) begin
      bad++; $display("FAIL rst_held got=%b want=%b", obs, V_ZERO);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs !== V_FETCH_WAIT) begin
        bad++; $display("FAIL rst_refetch%0d got=%b want=%b", i, obs, V_FETCH_WAIT);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    op = 7'b1111111;
    mem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== V_FETCH_GO) begin
      bad++; $display("FAIL ill_fetch got=%b want=%b", obs, V_FETCH_GO);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== V_DECODE) begin
      bad++; $display("FAIL ill_decode got=%b want=%b", obs, V_DECODE);
    end
    @(posedge clk); #1;
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      mem_ready = i[0];
      @(negedge clk);
      total++;
      if (obs !== V_ZERO || illegal_instr !== 1'b1) begin
        bad++; $display("FAIL ill_trap%0d got=%b/%b want=%b/1", i, obs, illegal_instr, V_ZERO);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== V_FETCH_WAIT || illegal_instr !== 1'b0) begin
      bad++; $display("FAIL ill_recover got=%b/%b want=%b/0", obs, illegal_instr, V_FETCH_WAIT);
    end
    @(posedge clk); #1;
`else
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== V_FETCH_WAIT) begin
        bad++; $display("FAIL ill_nop%0d got=%b want=%b", i, obs, V_FETCH_WAIT);
      end
      @(posedge clk); #1;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_rtype_ops();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_reset_mid_access();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
